// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads a 1-cycle synchronous instruction memory and queues
// fetched words in a small prefetch FIFO ahead of decode.
module instr_fetch_unit #(
    parameter int unsigned     INS_W      = 19,
    parameter int unsigned     PC_W       = 8,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        imem_en,
    output logic [PC_W-1:0]             imem_addr,
    input  logic [INS_W-1:0]            imem_rdata,
    output logic [INS_W-1:0]            ins,
    output logic [PC_W-1:0]             ins_pc,
    output logic                        ins_valid,
    input  logic                        ins_ready,
    input  logic                        redirect,
    input  logic [PC_W-1:0]             redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned      PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned      LVL_W        = PTR_W + 1;
    localparam logic [LVL_W:0]   DEPTH_CREDIT = (LVL_W + 1)'(FIFO_DEPTH);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  tag_pc_q;
    logic             inflight_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [INS_W-1:0] ins_mem_q [FIFO_DEPTH];
    logic [PC_W-1:0]  pc_mem_q  [FIFO_DEPTH];

    logic [LVL_W:0] credit_used;
    logic           push;
    logic           pop;
    logic           not_empty;

    // Words already in the FIFO plus the one in flight must leave room for the next return.
    always_comb begin
        credit_used = {1'b0, level_q} + (LVL_W + 1)'(inflight_q);
        imem_en     = ~reset & ~redirect & (credit_used < DEPTH_CREDIT);
        imem_addr   = fetch_pc_q;
        not_empty   = (level_q != '0);
        push        = inflight_q & ~redirect;
        ins_valid   = not_empty & ~redirect;
        pop         = ins_valid & ins_ready;
        ins         = not_empty ? ins_mem_q[rd_ptr_q] : '0;
        ins_pc      = not_empty ? pc_mem_q[rd_ptr_q] : '0;
        fifo_level  = level_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (imem_en) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
    end

    always_comb begin
        level_d = level_q;
        if (redirect) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= imem_en;
            level_q    <= level_d;
            if (imem_en) begin
                tag_pc_q <= fetch_pc_q;
            end
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ins_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]  <= tag_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver queues expected (pc, ins) pairs and a
// negedge monitor compares every accepted word against the queue head.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [18:0] imem_rdata = '0;
    logic [18:0] ins;
    logic [7:0]  ins_pc;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [2:0]  fifo_level;

    typedef struct packed {
        logic [7:0]  pc;
        logic [18:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;

    instr_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .ins_pc     (ins_pc),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] imem_word(logic [7:0] a);
        return 19'(a) + 19'd100;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_word(imem_addr);
    end

    task automatic check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_from(logic [7:0] start, int n);
        logic [7:0] pc;
        exp_q.delete();
        acc_cnt = 0;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: pc, ins: imem_word(pc)});
            pc = pc + 8'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && ins_valid && ins_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ins: got pc %0h ins %0h, expected none", ins_pc, ins);
            end else begin
                e = exp_q.pop_front();
                check("sb_ins_pc", ins_pc, e.pc);
                check("sb_ins", ins, e.ins);
                acc_cnt++;
            end
        end
    end

    initial begin
        // Reset state and first-word latency.
        expect_from(8'h00, 300);
        repeat (3) tick();
        @(negedge clk);
        check("rst_ins_valid", ins_valid, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_imem_en", imem_en, 0);
        check("rst_ins", ins, 0);
        check("rst_ins_pc", ins_pc, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("c0_imem_en", imem_en, 1);
        check("c0_imem_addr", imem_addr, 8'h00);
        check("c0_ins_valid", ins_valid, 0);
        @(negedge clk);
        check("c1_ins_valid", ins_valid, 0);
        @(negedge clk);
        check("c2_ins_valid", ins_valid, 1);
        check("c2_ins", ins, 100);
        repeat (4) tick();
        check("stream_accepts", acc_cnt >= 3, 1);

        // Stall: FIFO saturates, head held.
        reset = 1'b1;
        ins_ready = 1'b0;
        expect_from(8'h00, 300);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("stall_level", fifo_level, 4);
        check("stall_imem_en", imem_en, 0);
        check("stall_ins", ins, 100);
        check("stall_ins_pc", ins_pc, 0);
        check("stall_valid", ins_valid, 1);
        tick();
        ins_ready = 1'b1;
        repeat (6) tick();
        check("resume_accepts", acc_cnt >= 4, 1);

        // Redirect while FIFO holds 3 words.
        ins_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fifo_level == 3) break;
        end
        check("reach_level3", fifo_level, 3);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        expect_from(8'h40, 300);
        tick();
        redirect = 1'b0;
        ins_ready = 1'b1;
        @(negedge clk);
        check("redir_level", fifo_level, 0);
        check("redir_valid", ins_valid, 0);
        check("redir_imem_addr", imem_addr, 8'h40);
        @(negedge clk);
        check("redir_c1_valid", ins_valid, 0);
        @(negedge clk);
        check("redir_c2_valid", ins_valid, 1);
        check("redir_c2_pc", ins_pc, 8'h40);
        check("redir_c2_ins", ins, 164);
        repeat (4) tick();

        // PC wrap-around.
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        expect_from(8'hFE, 300);
        tick();
        redirect = 1'b0;
        repeat (8) tick();
        check("wrap_accepts", acc_cnt >= 4, 1);

        // Reset mid-stream with a full FIFO.
        ins_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fifo_level == 4) break;
        end
        check("reach_full", fifo_level, 4);
        reset = 1'b1;
        expect_from(8'h00, 300);
        @(negedge clk);
        check("midrst_imem_en", imem_en, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ins", ins, 0);
        check("midrst_ins_pc", ins_pc, 0);
        check("midrst_valid", ins_valid, 0);
        check("midrst_level", fifo_level, 0);
        tick();
        ins_ready = 1'b1;
        repeat (6) tick();
        check("midrst_accepts", acc_cnt >= 3, 1);

        // Random ready with two redirects.
        for (int i = 0; i < 200; i++) begin
            ins_ready = 1'($urandom_range(0, 1));
            if (i == 60 || i == 140) begin
                redirect = 1'b1;
                redirect_pc = 8'($urandom_range(0, 255));
                expect_from(redirect_pc, 300);
            end else begin
                redirect = 1'b0;
            end
            tick();
            check("level_bound", fifo_level <= 4, 1);
        end
        redirect = 1'b0;
        check("random_accepts", acc_cnt > 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
